// File: rtl/fifo_scheduler_pkg.sv
// Purpose : shared types and defaults for the FIFO write/read scheduler.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: scheduler state encoding, write/read priority encoding,
//           default NREQ/DATA_W/DEPTH, index-width helper.
package fifo_scheduler_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  // Operation driven in the current cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } sched_state_t;

  // Which side wins the next contested cycle.
  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_scheduler_rr_arbiter.sv
// Purpose : round-robin pick of one requester from an already-masked request vector.
// Latency : combinational; the caller registers the result.
// Backpres: none; an all-zero request vector yields an all-zero grant.
// Ports   : req        - eligible requesters (masking done by the caller)
//           last_grant - index of the most recently accepted requester
//           grant      - one-hot winner, search starting at last_grant+1 and wrapping
module rr_arbiter
  import fifo_scheduler_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant
);

  int   idx;
  logic found;

  // Walk offsets 1..NREQ from the last winner so the last winner is checked last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant) + off) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_scheduler.sv
// Purpose : picks at most one FIFO operation per cycle (one requester write or a consumer read).
// Latency : request sampled at edge N -> grant/fifo_en_w (or fifo_en_r) in cycle N+1; rd_valid one cycle after fifo_en_r.
// Backpres: writes stall when the tracked count is full, reads stall when it is empty; requesters hold req until granted.
// Ports   : clk, rst (async, active-high)
//           req/req_data    - per-requester write request and word (word i at [i*DATA_W +: DATA_W])
//           rd_req          - consumer drain request
//           grant           - one-hot acceptance pulse
//           fifo_en_w/fifo_data_in, fifo_en_r - registered FIFO controls
//           rd_valid        - FIFO read data valid
//           occupancy       - entry count tracked here (the FIFO's own flags are not used)
module fifo_scheduler
  import fifo_scheduler_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_W-1:0]       req_data,
  input  logic                         rd_req,
  output logic [NREQ-1:0]              grant,
  output logic                         fifo_en_w,
  output logic [DATA_W-1:0]            fifo_data_in,
  output logic                         fifo_en_r,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int                IDX_W    = idx_width(NREQ);
  localparam int                OCC_W    = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NREQ-1);

  sched_state_t      state, state_nxt;
  prio_t             prio, prio_nxt;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic [OCC_W-1:0]  occ_eff;
  logic [NREQ-1:0]   req_masked;
  logic [NREQ-1:0]   arb_grant;
  logic [DATA_W-1:0] data_sel;
  logic              wr_cand;
  logic              wr_demand;
  logic              rd_cand;
  logic              contested;

  // Count as it will stand once the operation in flight this cycle lands.
  // Decisions use this so a full/empty edge is never overrun by one cycle.
  always_comb begin
    occ_eff = occupancy;
    if (state == WRITE) begin
      occ_eff = occupancy + OCC_ONE;
    end else if (state == READ) begin
      occ_eff = occupancy - OCC_ONE;
    end
  end

  // A requester whose grant is high this cycle is still holding req (it only
  // drops after seeing the grant), so it must sit out one decision.
  assign req_masked = req & ~grant;

  assign wr_cand   = (|req_masked) && (occ_eff < OCC_FULL);
  assign rd_cand   = rd_req && (occ_eff != '0);

  // Contest counts raw write demand, including a requester masked by its own
  // grant. Otherwise a single requester would lose every contest right after
  // a win and the two sides would not alternate.
  assign wr_demand = (|req) && (occ_eff < OCC_FULL);
  assign contested = rd_cand && wr_demand;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req_masked),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  // Winner index and word for the registered write path.
  always_comb begin
    data_sel = '0;
    arb_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        data_sel = req_data[i*DATA_W +: DATA_W];
        arb_idx  = IDX_W'(i);
      end
    end
  end

  // Next operation and priority.
  always_comb begin
    state_nxt = IDLE;
    prio_nxt  = prio;
    if (wr_cand && rd_cand) begin
      state_nxt = (prio == PRIO_WRITE) ? WRITE : READ;
    end else if (wr_cand) begin
      state_nxt = WRITE;
    end else if (rd_cand) begin
      state_nxt = READ;
    end
    if (contested) begin
      prio_nxt = (prio == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prio         <= PRIO_WRITE;
      last_grant   <= LAST_RST;
      grant        <= '0;
      fifo_en_w    <= 1'b0;
      fifo_en_r    <= 1'b0;
      rd_valid     <= 1'b0;
      fifo_data_in <= '0;
      occupancy    <= '0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      occupancy <= occ_eff;
      grant     <= (state_nxt == WRITE) ? arb_grant : '0;
      fifo_en_w <= (state_nxt == WRITE);
      fifo_en_r <= (state_nxt == READ);
      rd_valid  <= fifo_en_r;
      // Word and round-robin pointer only move on an accepted write.
      if (state_nxt == WRITE) begin
        fifo_data_in <= data_sel;
        last_grant   <= arb_idx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_scheduler.sv
// Purpose : directed self-checking bench for fifo_scheduler (NREQ=4, DATA_W=32, DEPTH=8).
// Latency : n/a.
// Backpres: n/a.
module tb_fifo_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic         rd_req;
  logic [3:0]   grant;
  logic         fifo_en_w;
  logic [31:0]  fifo_data_in;
  logic         fifo_en_r;
  logic         rd_valid;
  logic [3:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_scheduler #(
    .NREQ   (4),
    .DATA_W (32),
    .DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .rd_req       (rd_req),
    .grant        (grant),
    .fifo_en_w    (fifo_en_w),
    .fifo_data_in (fifo_data_in),
    .fifo_en_r    (fifo_en_r),
    .rd_valid     (rd_valid),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_1011;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output check, plus the never-both-enables rule.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic ew,
                            input logic er, input logic rv, input logic [3:0] occ);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".en_w"},  32'(fifo_en_w), 32'(ew));
    chk({tag, ".en_r"},  32'(fifo_en_r), 32'(er));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({tag, ".occ"},   32'(occupancy), 32'(occ));
    chk({tag, ".excl"},  32'(fifo_en_w & fifo_en_r), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = word(i);

    // Reset state.
    #12;
    expect_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("reset.data", fifo_data_in, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four requesting: 0,1,2,3,0,1,2,3 then stop at full.
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out($sformatf("fill%0d", k), 4'(1 << (k % 4)), 1'b1, 1'b0, 1'b0, 4'(k));
      chk($sformatf("fill%0d.data", k), fifo_data_in, word(k % 4));
    end
    step();
    expect_out("full0", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd8);
    step();
    expect_out("full1", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd8);

    // Full with both sides requesting: read first, then the write.
    req    = 4'b0001;
    rd_req = 1'b1;
    step();
    expect_out("fullrd", 4'b0000, 1'b0, 1'b1, 1'b0, 4'd8);
    rd_req = 1'b0;
    step();
    expect_out("fullwr", 4'b0001, 1'b1, 1'b0, 1'b1, 4'd7);
    chk("fullwr.data", fifo_data_in, word(0));
    req = 4'b0000;
    step();
    expect_out("fullidle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd8);

    // Drain down to 4.
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out($sformatf("drain%0d", k), 4'b0000, 1'b0, 1'b1, (k > 0), 4'(8 - k));
      if (k == 3) rd_req = 1'b0;
    end
    step();
    expect_out("drainidle", 4'b0000, 1'b0, 1'b0, 1'b1, 4'd4);

    // Contested at occupancy 4: W,R,W,R,W,R with count 4/5.
    req    = 4'b0001;
    rd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k % 2 == 0)
        expect_out($sformatf("alt%0d", k), 4'b0001, 1'b1, 1'b0, (k > 0), 4'd4);
      else
        expect_out($sformatf("alt%0d", k), 4'b0000, 1'b0, 1'b1, 1'b0, 4'd5);
      if (k == 5) begin
        req    = 4'b0000;
        rd_req = 1'b0;
      end
    end
    step();
    expect_out("altidle", 4'b0000, 1'b0, 1'b0, 1'b1, 4'd4);

    // One read to reach 3.
    rd_req = 1'b1;
    step();
    expect_out("to3", 4'b0000, 1'b0, 1'b1, 1'b0, 4'd4);
    rd_req = 1'b0;
    step();
    expect_out("at3", 4'b0000, 1'b0, 1'b0, 1'b1, 4'd3);

    // Drain 3 -> 0 back-to-back, then no underflow.
    rd_req = 1'b1;
    step();
    expect_out("rd3", 4'b0000, 1'b0, 1'b1, 1'b0, 4'd3);
    step();
    expect_out("rd2", 4'b0000, 1'b0, 1'b1, 1'b1, 4'd2);
    step();
    expect_out("rd1", 4'b0000, 1'b0, 1'b1, 1'b1, 4'd1);
    step();
    expect_out("empty0", 4'b0000, 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    expect_out("empty1", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    rd_req = 1'b0;

    // Lone requester 2: grant every other cycle because of the mask.
    req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 2 == 0) begin
        expect_out($sformatf("solo%0d", k), 4'b0100, 1'b1, 1'b0, 1'b0, 4'(k / 2));
        chk($sformatf("solo%0d.data", k), fifo_data_in, word(2));
      end else begin
        expect_out($sformatf("solo%0d", k), 4'b0000, 1'b0, 1'b0, 1'b0, 4'((k + 1) / 2));
      end
    end

    // Async reset in the middle of a write cycle.
    step();
    expect_out("prerst", 4'b0100, 1'b1, 1'b0, 1'b0, 4'd4);
    #2;
    rst = 1'b1;
    #1;
    expect_out("asyncrst", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("asyncrst.data", fifo_data_in, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0000;
    step();
    expect_out("post1", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    req = 4'b1000;
    step();
    expect_out("post2", 4'b1000, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("post2.data", fifo_data_in, word(3));
    req = 4'b0000;
    step();
    expect_out("post3", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
